// File: rtl/spi_master_multi.sv
// Byte-wide SPI master on the CPU I/O bus.
// Supports NUM_CS software chip selects, all four CPOL/CPHA modes,
// MSB/LSB-first order and a runtime half-period divider.
module spi_master_multi #(
   parameter int               NUM_CS    = 4,
   parameter int               DIV_W     = 8,
   parameter logic [DIV_W-1:0] DIV_RESET = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              we,
   input  logic [2:0]        addr,
   input  logic [7:0]        din,
   output logic [7:0]        dout,
   output logic              irq,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              spi_sclk,
   output logic [NUM_CS-1:0] spi_cs_n
);
   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_STATUS = 3'd1;
   localparam logic [2:0] A_CTRL   = 3'd2;
   localparam logic [2:0] A_DIV    = 3'd3;
   localparam logic [2:0] A_CSREG  = 3'd4;

   state_t             state, state_nx;
   logic [3:0]         ctrl;          // {irq_en, lsb_first, cpha, cpol}
   logic [DIV_W-1:0]   div, w_div, cnt;
   logic [NUM_CS-1:0]  csreg;
   logic [7:0]         rx, tx_sh, rx_sh, rx_shin;
   logic [3:0]         edge_cnt;      // sclk edges already produced, 0..15
   logic               done, busy, w_cpha, w_lsb, sclk_r, mosi_r;
   logic               wr, rd_data, start, wrap, last, drive_edge, sample_edge;
   logic               tx_bit;

   // Shift one position toward the bit that goes out next.
   function automatic logic [7:0] shl(input logic [7:0] x, input logic lsb);
      return lsb ? {1'b0, x[7:1]} : {x[6:0], 1'b0};
   endfunction

   assign wr      = cs & we;
   assign rd_data = cs & ~we & (addr == A_DATA);
   assign busy    = (state == SHIFT);
   assign tx_bit  = w_lsb ? tx_sh[0] : tx_sh[7];
   assign rx_shin = w_lsb ? {spi_miso, rx_sh[7:1]} : {rx_sh[6:0], spi_miso};

   // Edge number is edge_cnt+1, so an odd edge has edge_cnt[0]==0.
   // CPHA=0 samples odd / drives even (2..14); CPHA=1 drives odd / samples even.
   assign sample_edge = wrap & (w_cpha ? edge_cnt[0] : ~edge_cnt[0]);
   assign drive_edge  = wrap & ~last & (w_cpha ? ~edge_cnt[0] : edge_cnt[0]);

   // Next-state logic and transfer strobes.
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      wrap     = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: begin
            if (wr && addr == A_DATA) begin
               start    = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            wrap = (cnt == w_div);
            last = wrap && (edge_cnt == 4'd15);
            if (last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Software-visible configuration registers; writable at any time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl  <= '0;
         div   <= DIV_RESET;
         csreg <= '0;
      end else if (wr) begin
         case (addr)
            A_CTRL:  ctrl  <= din[3:0];
            A_DIV:   div   <= DIV_W'(din);
            A_CSREG: csreg <= din[NUM_CS-1:0];
            default: ;
         endcase
      end
   end

   // State register, shift engine, RX capture and done flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         w_div    <= '0;
         w_cpha   <= 1'b0;
         w_lsb    <= 1'b0;
         cnt      <= '0;
         edge_cnt <= '0;
         sclk_r   <= 1'b0;
         mosi_r   <= 1'b0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         rx       <= '0;
         done     <= 1'b0;
      end else begin
         state <= state_nx;
         // Completion wins over a same-cycle DATA read so it is never lost.
         if (last)                  done <= 1'b1;
         else if (start || rd_data) done <= 1'b0;
         if (start) begin
            // Working copies freeze the mode for the whole transfer;
            // sclk_r starts at the latched CPOL.
            w_div    <= div;
            w_cpha   <= ctrl[1];
            w_lsb    <= ctrl[2];
            cnt      <= '0;
            edge_cnt <= '0;
            sclk_r   <= ctrl[0];
            rx_sh    <= '0;
            if (!ctrl[1]) begin
               mosi_r <= ctrl[2] ? din[0] : din[7];
               tx_sh  <= shl(din, ctrl[2]);
            end else begin
               tx_sh  <= din;
            end
         end else if (busy) begin
            if (wrap) begin
               cnt      <= '0;
               sclk_r   <= ~sclk_r;
               edge_cnt <= edge_cnt + 4'd1;
               if (sample_edge) rx_sh <= rx_shin;
               if (drive_edge) begin
                  mosi_r <= tx_bit;
                  tx_sh  <= shl(tx_sh, w_lsb);
               end
               // CPHA=1 takes its final sample on edge 16 itself.
               if (last) rx <= w_cpha ? rx_shin : rx_sh;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // Register read mux, combinational on addr.
   always_comb begin
      dout = 8'h00;
      case (addr)
         A_DATA:   dout = rx;
         A_STATUS: dout = {6'b0, done, busy};
         A_CTRL:   dout = {4'b0, ctrl};
         A_DIV:    dout = 8'(div);
         A_CSREG:  dout = 8'(csreg);
         default:  dout = 8'h00;
      endcase
   end

   // Idle sclk tracks the live CPOL so a CTRL write shows up right away.
   assign spi_sclk = busy ? sclk_r : ctrl[0];
   assign spi_mosi = mosi_r;
   assign spi_cs_n = ~csreg;
   assign irq      = done & ctrl[3];

endmodule
